// File: rtl/types.sv
// Shared data types for the register-file datapath.
package types;
    typedef logic [31:0] register;
endpackage

// File: rtl/writeback_queue.sv
// In-order writeback FIFO that drains up to two results per cycle onto the register file write ports.
// Optional build macro WBQ_ZERO_DISCARD_EN: entries targeting index 0 are popped but never raise an enable.
module writeback_queue #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    src0_valid,
    output logic                    src0_ready,
    input  logic [IDX_W-1:0]        src0_rd,
    input  types::register          src0_value,
    input  logic                    src1_valid,
    output logic                    src1_ready,
    input  logic [IDX_W-1:0]        src1_rd,
    input  types::register          src1_value,
    input  logic                    stall,
    input  logic                    flush,
    output logic [IDX_W-1:0]        write1,
    output logic                    write1_enable,
    output types::register          write1_value,
    output logic [IDX_W-1:0]        write2,
    output logic                    write2_enable,
    output types::register          write2_value,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [IDX_W-1:0] rd;
        types::register   value;
    } entry_t;

    entry_t        r_mem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_enq0;
    logic          w_enq1;
    logic [1:0]    w_enq;
    logic [1:0]    w_deq;
    logic          w_hold;
    logic          w_keep0;
    logic          w_keep1;
    entry_t        w_e0;
    entry_t        w_e1;

    // Ready limits look only at the registered count, so there is no valid->ready path.
    assign src0_ready = (r_count <= CW'(DEPTH - 1));
    assign src1_ready = (r_count <= CW'(DEPTH - 2));
    assign count      = r_count;
    assign empty      = (r_count == '0);

    assign w_enq0 = src0_valid && src0_ready && !flush;
    assign w_enq1 = src1_valid && src1_ready && !flush;
    assign w_enq  = {1'b0, w_enq0} + {1'b0, w_enq1};
    assign w_hold = stall || flush;

    assign w_e0 = r_mem[r_head];
    assign w_e1 = r_mem[r_head + AW'(1)];

`ifdef WBQ_ZERO_DISCARD_EN
    assign w_keep0 = (w_e0.rd != '0);
    assign w_keep1 = (w_e1.rd != '0);
`else
    assign w_keep0 = 1'b1;
    assign w_keep1 = 1'b1;
`endif

    // Storage is intentionally left out of reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (w_enq0) begin
            r_mem[r_tail] <= {src0_rd, src0_value};
        end
        if (w_enq1) begin
            r_mem[w_enq0 ? r_tail + AW'(1) : r_tail] <= {src1_rd, src1_value};
        end
    end

    always_comb begin
        write1        = w_e0.rd;
        write1_value  = w_e0.value;
        write1_enable = 1'b0;
        write2        = w_e1.rd;
        write2_value  = w_e1.value;
        write2_enable = 1'b0;
        w_deq         = 2'd0;
        if (!w_hold) begin
            if (r_count == CW'(1)) begin
                w_deq         = 2'd1;
                write1_enable = w_keep0;
            end else if (r_count >= CW'(2)) begin
                w_deq = 2'd2;
                if (w_keep0 && w_keep1) begin
                    // Same index in the pair: only the younger value is written.
                    if (w_e0.rd == w_e1.rd) begin
                        write1        = w_e1.rd;
                        write1_value  = w_e1.value;
                        write1_enable = 1'b1;
                    end else begin
                        write1_enable = 1'b1;
                        write2_enable = 1'b1;
                    end
                end else if (w_keep0) begin
                    write1_enable = 1'b1;
                end else if (w_keep1) begin
                    write1        = w_e1.rd;
                    write1_value  = w_e1.value;
                    write1_enable = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(w_deq);
            r_tail  <= r_tail + AW'(w_enq);
            r_count <= r_count + CW'(w_enq) - CW'(w_deq);
        end
    end
endmodule

// File: tb/tb_writeback_queue.sv
// Randomized bench for writeback_queue against a queue-based reference model.
module tb_writeback_queue;
    logic        clk;
    logic        rst_n;
    logic        src0_valid, src1_valid;
    logic        src0_ready, src1_ready;
    logic [4:0]  src0_rd, src1_rd;
    logic [31:0] src0_value, src1_value;
    logic        stall, flush;
    logic [4:0]  write1, write2;
    logic        write1_enable, write2_enable;
    logic [31:0] write1_value, write2_value;
    logic [3:0]  count;
    logic        empty;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] v;
    } ent_t;

    ent_t        q[$];
    logic [31:0] exp_rf [32];
    logic [31:0] dut_rf [32];
    int          n_checks = 0;
    int          n_errors = 0;

    writeback_queue #(.DEPTH(8), .IDX_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .src0_valid(src0_valid), .src0_ready(src0_ready), .src0_rd(src0_rd), .src0_value(src0_value),
        .src1_valid(src1_valid), .src1_ready(src1_ready), .src1_rd(src1_rd), .src1_value(src1_value),
        .stall(stall), .flush(flush),
        .write1(write1), .write1_enable(write1_enable), .write1_value(write1_value),
        .write2(write2), .write2_enable(write2_enable), .write2_value(write2_value),
        .count(count), .empty(empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit kept(input logic [4:0] rd);
`ifdef WBQ_ZERO_DISCARD_EN
        return rd != 5'd0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic idle_inputs();
        src0_valid = 0; src1_valid = 0; stall = 0; flush = 0;
    endtask

    // Called at a negedge; drives one cycle, checks against the model, returns at the next negedge.
    task automatic cycle(input bit v0, input logic [4:0] rd0, input logic [31:0] d0,
                         input bit v1, input logic [4:0] rd1, input logic [31:0] d1,
                         input bit st, input bit fl);
        ent_t lst[$];
        ent_t x1, x2;
        int   cnt, npop;
        bit   r0, r1, e1en, e2en;
        x1 = '{5'd0, 32'd0};
        x2 = '{5'd0, 32'd0};
        src0_valid = v0; src0_rd = rd0; src0_value = d0;
        src1_valid = v1; src1_rd = rd1; src1_value = d1;
        stall = st; flush = fl;
        #2;
        cnt  = q.size();
        r0   = (cnt <= 7);
        r1   = (cnt <= 6);
        npop = (st || fl) ? 0 : ((cnt >= 2) ? 2 : cnt);
        for (int i = 0; i < npop; i++) if (kept(q[i].rd)) lst.push_back(q[i]);
        e1en = 0; e2en = 0;
        if (lst.size() == 2 && lst[0].rd == lst[1].rd) begin
            e1en = 1; x1 = lst[1];
        end else if (lst.size() == 2) begin
            e1en = 1; e2en = 1; x1 = lst[0]; x2 = lst[1];
        end else if (lst.size() == 1) begin
            e1en = 1; x1 = lst[0];
        end
        chk("count", count, cnt);
        chk("empty", empty, cnt == 0);
        chk("src0_ready", src0_ready, r0);
        chk("src1_ready", src1_ready, r1);
        chk("write1_enable", write1_enable, e1en);
        chk("write2_enable", write2_enable, e2en);
        if (e1en) begin
            chk("write1", write1, x1.rd);
            chk("write1_value", write1_value, x1.v);
        end
        if (e2en) begin
            chk("write2", write2, x2.rd);
            chk("write2_value", write2_value, x2.v);
        end
        if (write1_enable) dut_rf[write1] = write1_value;
        if (write2_enable) dut_rf[write2] = write2_value;
        foreach (lst[i]) exp_rf[lst[i].rd] = lst[i].v;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            repeat (npop) void'(q.pop_front());
            if (v0 && r0) q.push_back('{rd0, d0});
            if (v1 && r1) q.push_back('{rd1, d1});
        end
        @(negedge clk);
    endtask

    task automatic nop(input bit st);
        cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, st, 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            exp_rf[i] = 32'd0;
            dut_rf[i] = 32'd0;
        end
        rst_n = 0;
        src0_rd = 0; src0_value = 0; src1_rd = 0; src1_value = 0;
        idle_inputs();
        repeat (2) @(negedge clk);
        #2;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_w1en", write1_enable, 0);
        chk("rst_w2en", write2_enable, 0);
        chk("rst_src0_ready", src0_ready, 1);
        chk("rst_src1_ready", src1_ready, 1);
        @(negedge clk);
        rst_n = 1;
        nop(0); nop(0);

        // Dual enqueue, distinct indices
        cycle(1, 5'd3, 32'h11, 1, 5'd7, 32'h22, 0, 0);
        idle_inputs();
        #1;
        chk("dual_w1", write1, 3);
        chk("dual_v1", write1_value, 32'h11);
        chk("dual_w2", write2, 7);
        chk("dual_v2", write2_value, 32'h22);
        chk("dual_en2", write2_enable, 1);
        nop(0);
        chk("dual_count_after", count, 0);

        // Coalesce on equal index
        cycle(1, 5'd5, 32'hAA, 1, 5'd5, 32'hBB, 0, 0);
        idle_inputs();
        #1;
        chk("coal_w1", write1, 5);
        chk("coal_v1", write1_value, 32'hBB);
        chk("coal_en2", write2_enable, 0);
        nop(0);
        chk("coal_rf5", dut_rf[5], 32'hBB);

        // Backpressure under stall
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                chk("bp_src1_ready_at7", src1_ready, 0);
                chk("bp_src0_ready_at7", src0_ready, 1);
            end
            cycle(1, 5'(i + 1), 32'h100 + 32'(i), 0, 5'd0, 32'd0, 1, 0);
        end
        chk("bp_src0_ready_at8", src0_ready, 0);
        cycle(1, 5'd9, 32'h999, 1, 5'd10, 32'h998, 1, 0);
        chk("bp_count_full", count, 8);
        for (int k = 0; k < 4; k++) begin
            nop(0);
            chk("bp_drain_count", count, 4'(8 - 2 * (k + 1)));
        end

        // Flush with a simultaneous enqueue that must be ignored
        for (int i = 0; i < 5; i++) cycle(1, 5'(i + 11), 32'h200 + 32'(i), 0, 5'd0, 32'd0, 1, 0);
        cycle(1, 5'd20, 32'h300, 1, 5'd21, 32'h301, 0, 1);
        chk("flush_count", count, 0);
        chk("flush_src1_ready", src1_ready, 1);

        // Async reset between edges
        for (int i = 0; i < 3; i++) cycle(1, 5'(i + 1), 32'h400 + 32'(i), 0, 5'd0, 32'd0, 1, 0);
        idle_inputs();
        stall = 1;
        #2 rst_n = 0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_empty", empty, 1);
        chk("arst_w1en", write1_enable, 0);
        q.delete();
        #1 rst_n = 1;
        @(negedge clk);
        nop(0);

`ifdef WBQ_ZERO_DISCARD_EN
        cycle(1, 5'd0, 32'h1, 1, 5'd4, 32'h2, 0, 0);
        idle_inputs();
        #1;
        chk("zd_w1", write1, 4);
        chk("zd_v1", write1_value, 32'h2);
        chk("zd_en1", write1_enable, 1);
        chk("zd_en2", write2_enable, 0);
        nop(0);
        chk("zd_count", count, 0);
`endif

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            cycle($urandom_range(0, 4) < 3, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 4) < 3, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0);
        end
        for (int n = 0; n < 6; n++) nop(0);

        for (int i = 0; i < 32; i++) chk($sformatf("rf[%0d]", i), dut_rf[i], exp_rf[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
